// File: rtl/lane_seg_top_acc_requant.sv
// Dot-product accumulator with saturating accumulation, round-half-up
// requantization and a signed output clamp, with AXI-Stream style handshakes.
// Optional feature: define LANE_SEG_RELU_EN to zero negative results.
module lane_seg_top_acc_requant #(
    parameter int IN_W  = 26,
    parameter int ACC_W = 32,
    parameter int SHIFT = 10,
    parameter int OUT_W = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [IN_W-1:0]  prod_tdata,
    input  logic             prod_tvalid,
    input  logic             prod_tlast,
    output logic             prod_tready,
    output logic [OUT_W-1:0] res_tdata,
    output logic             res_tvalid,
    input  logic             res_tready,
    output logic             ovf_o
);

    typedef enum logic [1:0] {IDLE, ACC, RND, OUT} state_t;

    localparam logic signed [ACC_W:0] ACC_MAX  = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_MIN  = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0] OUT_MAX  = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN  = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W:0] RND_BIAS = {{ACC_W{1'b0}}, 1'b1} << (SHIFT-1);

    state_t                   state, state_next;
    logic signed [ACC_W-1:0]  acc, acc_next;
    logic [OUT_W-1:0]         res_next;
    logic                     res_valid_next;
    logic                     ovf_next;
    logic                     tready_next;

    logic signed [ACC_W:0]    prod_ext;
    logic signed [ACC_W:0]    sum_wide;
    logic signed [ACC_W-1:0]  sum_sat;
    logic                     sat;
    logic signed [ACC_W:0]    rnd_wide;
    logic signed [ACC_W:0]    shifted;
    logic [OUT_W-1:0]         clamped;
    logic                     clamp;

    // Saturating accumulate: one guard bit detects overflow of the ACC_W-bit sum.
    always_comb begin
        prod_ext = {{(ACC_W+1-IN_W){prod_tdata[IN_W-1]}}, prod_tdata};
        sum_wide = (state == IDLE) ? prod_ext : ({acc[ACC_W-1], acc} + prod_ext);
        sat      = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (!sat)
            sum_sat = sum_wide[ACC_W-1:0];
        else if (sum_wide[ACC_W])
            sum_sat = ACC_MIN[ACC_W-1:0];
        else
            sum_sat = ACC_MAX[ACC_W-1:0];
    end

    // Round-half-up arithmetic shift followed by the output range clamp.
    always_comb begin
        rnd_wide = {acc[ACC_W-1], acc} + RND_BIAS;
        shifted  = rnd_wide >>> SHIFT;
        clamped  = shifted[OUT_W-1:0];
        clamp    = 1'b0;
`ifdef LANE_SEG_RELU_EN
        // Negative results become zero; this is not an overflow event.
        if (shifted[ACC_W]) begin
            clamped = '0;
        end else if (shifted > OUT_MAX) begin
            clamped = OUT_MAX[OUT_W-1:0];
            clamp   = 1'b1;
        end
`else
        if (shifted > OUT_MAX) begin
            clamped = OUT_MAX[OUT_W-1:0];
            clamp   = 1'b1;
        end else if (shifted < OUT_MIN) begin
            clamped = OUT_MIN[OUT_W-1:0];
            clamp   = 1'b1;
        end
`endif
    end

    // Next-state and output decode for the IDLE/ACC/RND/OUT sequence.
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        res_next       = res_tdata;
        res_valid_next = res_tvalid;
        ovf_next       = ovf_o;
        case (state)
            IDLE, ACC: begin
                if (prod_tvalid && prod_tready) begin
                    acc_next   = sum_sat;
                    ovf_next   = ovf_o | sat;
                    state_next = prod_tlast ? RND : ACC;
                end
            end
            RND: begin
                res_next       = clamped;
                res_valid_next = 1'b1;
                ovf_next       = ovf_o | clamp;
                state_next     = OUT;
            end
            OUT: begin
                if (res_tready) begin
                    res_valid_next = 1'b0;
                    acc_next       = '0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Registered ready follows the next state, so it stays low through reset
        // and never depends combinationally on prod_tvalid.
        tready_next = (state_next == IDLE) || (state_next == ACC);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            res_tdata   <= '0;
            res_tvalid  <= 1'b0;
            prod_tready <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            res_tdata   <= res_next;
            res_tvalid  <= res_valid_next;
            prod_tready <= tready_next;
            ovf_o       <= ovf_next;
        end
    end

endmodule
